// File: rtl/decode.sv
// Instruction decode stage: 8x16 register file, field decode and a registered execution bundle.
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle writeback to the register-file read.
module decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_i,
    input  logic [15:0] instr_i,
    output logic        instr_ready_o,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_addr_i,
    input  logic [15:0] wb_data_i,
    output logic        out_valid_o,
    output logic        pc_w_o,
    output logic        mem_w_o,
    output logic        is_eq_o,
    output logic        is_ldi_o,
    output logic        is_ld_st_o,
    output logic        is_jump_o,
    output logic [1:0]  alith_o,
    output logic [2:0]  rd_addr_o,
    output logic [5:0]  disp6_o,
    output logic [8:0]  imm9_o,
    output logic [15:0] rd_o,
    output logic [15:0] rs_o,
    output logic [15:0] source1_o,
    output logic [15:0] source2_o,
    output logic        halted_o
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    typedef struct packed {
        logic        valid;
        logic        pc_w;
        logic        mem_w;
        logic        is_eq;
        logic        is_ldi;
        logic        is_ld_st;
        logic        is_jump;
        logic [1:0]  alith;
        logic [2:0]  rd_addr;
        logic [5:0]  disp6;
        logic [8:0]  imm9;
        logic [15:0] rd;
        logic [15:0] rs;
        logic [15:0] src1;
        logic [15:0] src2;
    } ex_t;

    localparam logic [3:0] OpAdd  = 4'h0, OpSub  = 4'h1, OpAnd  = 4'h2, OpOr   = 4'h3;
    localparam logic [3:0] OpAddi = 4'h4, OpSubi = 4'h5, OpIncr = 4'h6, OpDecr = 4'h7;
    localparam logic [3:0] OpLdi  = 4'h8, OpLd   = 4'h9, OpSt   = 4'hA, OpBeq  = 4'hB;
    localparam logic [3:0] OpBgt  = 4'hC, OpJump = 4'hD, OpHalt = 4'hF;

    state_e      state_q, state_d;
    ex_t         out_q, out_d, dec;
    logic [15:0] rf_q [8];
    logic [15:0] rd_val, rs_val;
    logic        xfer;

    logic [3:0]  opcode;
    logic [2:0]  rd_f, rs_f;
    logic [15:0] imm9_zx, imm9_sx, disp6_sx;

    assign opcode   = instr_i[15:12];
    assign rd_f     = instr_i[11:9];
    assign rs_f     = instr_i[8:6];
    assign imm9_zx  = {7'd0, instr_i[8:0]};
    assign imm9_sx  = {{7{instr_i[8]}}, instr_i[8:0]};
    assign disp6_sx = {{10{instr_i[5]}}, instr_i[5:0]};

    // R0 is never written, so rf_q[0] stays zero and reads of R0 return 0.
`ifdef DECODE_WB_BYPASS_EN
    assign rd_val = (wb_we_i && wb_addr_i == rd_f && rd_f != 3'd0) ? wb_data_i : rf_q[rd_f];
    assign rs_val = (wb_we_i && wb_addr_i == rs_f && rs_f != 3'd0) ? wb_data_i : rf_q[rs_f];
`else
    assign rd_val = rf_q[rd_f];
    assign rs_val = rf_q[rs_f];
`endif

    assign instr_ready_o = !stall_i && (state_q == StRun);
    assign xfer          = instr_valid_i && instr_ready_o;

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.disp6 = instr_i[5:0];
        dec.imm9  = instr_i[8:0];
        dec.rd    = rd_val;
        dec.rs    = rs_val;
        case (opcode)
            OpAdd, OpSub, OpAnd, OpOr: begin
                dec.rd_addr = rd_f;
                dec.alith   = opcode[1:0];
                dec.src1    = rd_val;
                dec.src2    = rs_val;
            end
            OpAddi, OpSubi: begin
                dec.rd_addr = rd_f;
                dec.alith   = (opcode == OpSubi) ? 2'b01 : 2'b00;
                dec.src1    = rd_val;
                dec.src2    = imm9_zx;
            end
            OpIncr, OpDecr: begin
                dec.rd_addr = rd_f;
                dec.alith   = (opcode == OpDecr) ? 2'b01 : 2'b00;
                dec.src1    = rd_val;
                dec.src2    = 16'd1;
            end
            OpLdi: begin
                dec.is_ldi  = 1'b1;
                dec.rd_addr = rd_f;
                dec.src1    = rd_val;
                dec.src2    = imm9_zx;
            end
            OpLd, OpSt: begin
                dec.is_ld_st = 1'b1;
                dec.mem_w    = (opcode == OpSt);
                dec.rd_addr  = (opcode == OpLd) ? rd_f : 3'd0;
                dec.src1     = rd_val;
                dec.src2     = disp6_sx;
            end
            OpBeq, OpBgt: begin
                dec.pc_w  = 1'b1;
                dec.is_eq = (opcode == OpBeq);
                dec.src2  = disp6_sx;
            end
            OpJump: begin
                dec.pc_w    = 1'b1;
                dec.is_jump = 1'b1;
                dec.src2    = imm9_sx;
            end
            default: ;
        endcase
    end

    // Flush beats stall; an idle cycle without stall produces a bubble.
    always_comb begin
        out_d   = out_q;
        state_d = state_q;
        if (flush_i) begin
            out_d = '0;
        end else if (!stall_i) begin
            out_d = xfer ? dec : '0;
            if (xfer && opcode == OpHalt) begin
                state_d = StHalted;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we_i && wb_addr_i != 3'd0) begin
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign out_valid_o = out_q.valid;
    assign pc_w_o      = out_q.pc_w;
    assign mem_w_o     = out_q.mem_w;
    assign is_eq_o     = out_q.is_eq;
    assign is_ldi_o    = out_q.is_ldi;
    assign is_ld_st_o  = out_q.is_ld_st;
    assign is_jump_o   = out_q.is_jump;
    assign alith_o     = out_q.alith;
    assign rd_addr_o   = out_q.rd_addr;
    assign disp6_o     = out_q.disp6;
    assign imm9_o      = out_q.imm9;
    assign rd_o        = out_q.rd;
    assign rs_o        = out_q.rs;
    assign source1_o   = out_q.src1;
    assign source2_o   = out_q.src2;
    assign halted_o    = (state_q == StHalted);

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed vector table, stall/halt/bypass sequences, then random traffic
// checked against a mnemonic-level reference model.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, stall, flush, wb_we;
    logic [15:0] instr, wb_data;
    logic [2:0]  wb_addr;
    logic        instr_ready, out_valid, pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump, halted;
    logic [1:0]  alith;
    logic [2:0]  rd_addr;
    logic [5:0]  disp6;
    logic [8:0]  imm9;
    logic [15:0] rd, rs, source1, source2;

    always #5 clk = ~clk;

    decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid_i(instr_valid),
        .instr_i      (instr),
        .instr_ready_o(instr_ready),
        .stall_i      (stall),
        .flush_i      (flush),
        .wb_we_i      (wb_we),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .out_valid_o  (out_valid),
        .pc_w_o       (pc_w),
        .mem_w_o      (mem_w),
        .is_eq_o      (is_eq),
        .is_ldi_o     (is_ldi),
        .is_ld_st_o   (is_ld_st),
        .is_jump_o    (is_jump),
        .alith_o      (alith),
        .rd_addr_o    (rd_addr),
        .disp6_o      (disp6),
        .imm9_o       (imm9),
        .rd_o         (rd),
        .rs_o         (rs),
        .source1_o    (source1),
        .source2_o    (source2),
        .halted_o     (halted)
    );

    typedef struct packed {
        logic        valid;
        logic [5:0]  flags;  // pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump
        logic [1:0]  alith;
        logic [2:0]  rd_addr;
        logic [5:0]  disp6;
        logic [8:0]  imm9;
        logic [15:0] rd;
        logic [15:0] rs;
        logic [15:0] s1;
        logic [15:0] s2;
    } out_t;

    typedef struct packed {
        logic        v;
        logic [15:0] ins;
        logic        fl;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ev;
        logic [5:0]  eflags;
        logic [1:0]  ealu;
        logic [2:0]  erd;
        logic [15:0] es1;
        logic [15:0] es2;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_regs [8];
    out_t        m_out;
    bit          m_halted;

    function automatic out_t dut_out();
        return {out_valid, pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump, alith, rd_addr,
                disp6, imm9, rd, rs, source1, source2};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a, input logic we,
                                               input logic [2:0] wa, input logic [15:0] wd);
        if (a == 3'd0) return 16'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    // Reference: each mnemonic's effect stated directly from the instruction-set table.
    function automatic out_t ref_decode(input logic [15:0] ins, input logic [15:0] rdv,
                                        input logic [15:0] rsv);
        out_t        o;
        int          op;
        logic [15:0] zimm, simm, sdisp;
        o       = '0;
        op      = int'(ins[15:12]);
        zimm    = 16'(ins[8:0]);
        simm    = 16'($signed(ins[8:0]));
        sdisp   = 16'($signed(ins[5:0]));
        o.valid = 1'b1;
        o.disp6 = ins[5:0];
        o.imm9  = ins[8:0];
        o.rd    = rdv;
        o.rs    = rsv;
        case (op)
            0:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = rsv;                 end
            1:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = rsv;   o.alith = 1;  end
            2:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = rsv;   o.alith = 2;  end
            3:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = rsv;   o.alith = 3;  end
            4:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = zimm;                end
            5:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = zimm;  o.alith = 1;  end
            6:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = 1;                   end
            7:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = 1;     o.alith = 1;  end
            8:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = zimm;  o.flags = 6'b000100; end
            9:  begin o.rd_addr = ins[11:9]; o.s1 = rdv; o.s2 = sdisp; o.flags = 6'b000010; end
            10: begin o.s1 = rdv; o.s2 = sdisp; o.flags = 6'b010010; end
            11: begin o.s2 = sdisp; o.flags = 6'b101000; end
            12: begin o.s2 = sdisp; o.flags = 6'b100000; end
            13: begin o.s2 = simm;  o.flags = 6'b100001; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input logic v, input logic [15:0] ins, input logic st, input logic fl,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd);
        out_t nxt;
        logic take;
        instr_valid = v;
        instr       = ins;
        stall       = st;
        flush       = fl;
        wb_we       = we;
        wb_addr     = wa;
        wb_data     = wd;
        take = v && !st && !m_halted;
        if (fl)        nxt = '0;
        else if (st)   nxt = m_out;
        else if (take) nxt = ref_decode(ins, model_read(ins[11:9], we, wa, wd),
                                        model_read(ins[8:6], we, wa, wd));
        else           nxt = '0;
        #1;
        chk("instr_ready", 128'(instr_ready), 128'(!st && !m_halted));
        @(posedge clk);
        m_out = nxt;
        if (take && !fl && ins[15:12] == 4'hF) m_halted = 1'b1;
        if (we && wa != 3'd0) m_regs[wa] = wd;
        #1;
        chk("outputs", 128'(dut_out()), 128'(m_out));
        chk("halted", 128'(halted), 128'(m_halted));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("async_reset_out", 128'(dut_out()), 128'd0);
        chk("async_reset_halted", 128'(halted), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_out    = '0;
        m_halted = 1'b0;
    endtask

    vec_t tbl [15];
    out_t snap;

    initial begin
        instr_valid = 0; instr = 0; stall = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        do_reset();
        chk("ready_after_reset", 128'(instr_ready), 128'd1);

        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'd10, 1'b0, 6'b000000, 2'd0, 3'd0, 16'd0, 16'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'd20, 1'b0, 6'b000000, 2'd0, 3'd0, 16'd0, 16'd0};
        tbl[2]  = '{1'b1, 16'h0288, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000000, 2'd0, 3'd1, 16'd10, 16'd20};
        tbl[3]  = '{1'b1, 16'h9283, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000010, 2'd0, 3'd1, 16'd10, 16'd3};
        tbl[4]  = '{1'b1, 16'hA283, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b010010, 2'd0, 3'd0, 16'd10, 16'd3};
        tbl[5]  = '{1'b1, 16'hB03F, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b101000, 2'd0, 3'd0, 16'd0, 16'hFFFF};
        tbl[6]  = '{1'b1, 16'hB03F, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 6'b000000, 2'd0, 3'd0, 16'd0, 16'd0};
        tbl[7]  = '{1'b1, 16'hD100, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b100001, 2'd0, 3'd0, 16'd0, 16'hFF00};
        tbl[8]  = '{1'b1, 16'h4203, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000000, 2'd0, 3'd1, 16'd10, 16'd3};
        tbl[9]  = '{1'b1, 16'h6400, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000000, 2'd0, 3'd2, 16'd20, 16'd1};
        tbl[10] = '{1'b1, 16'h5405, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000000, 2'd1, 3'd2, 16'd20, 16'd5};
        tbl[11] = '{1'b1, 16'h87AB, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000100, 2'd0, 3'd3, 16'd0, 16'h01AB};
        tbl[12] = '{1'b1, 16'h3280, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000000, 2'd3, 3'd1, 16'd10, 16'd20};
        tbl[13] = '{1'b1, 16'hC005, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b100000, 2'd0, 3'd0, 16'd0, 16'd5};
        tbl[14] = '{1'b1, 16'hE000, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 6'b000000, 2'd0, 3'd0, 16'd0, 16'd0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].ins, 1'b0, tbl[i].fl, tbl[i].we, tbl[i].wa, tbl[i].wd);
            chk($sformatf("vec%0d", i),
                128'({out_valid, pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump, alith, rd_addr,
                      source1, source2}),
                128'({tbl[i].ev, tbl[i].eflags, tbl[i].ealu, tbl[i].erd, tbl[i].es1, tbl[i].es2}));
        end

        // Stall held for three cycles behind ADDI R1,3, then released onto ADD.
        step(1'b1, 16'h4203, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0288, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
            chk("stall_hold", 128'({out_valid, rd_addr, source1, source2}),
                128'({1'b1, 3'd1, 16'd10, 16'd3}));
        end
        step(1'b1, 16'h0288, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("stall_release", 128'({out_valid, source1, source2}), 128'({1'b1, 16'd10, 16'd20}));

        // Same-cycle writeback of R3 while ADD R3,R0 reads it.
        step(1'b1, 16'h0600, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234);
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_same_cycle", 128'(source1), 128'h1234);
`else
        chk("wb_same_cycle", 128'(source1), 128'h0000);
`endif
        step(1'b1, 16'h0600, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("wb_next_cycle", 128'(source1), 128'h1234);

        // HALT with flush is dropped; plain HALT stops decode until reset.
        step(1'b1, 16'hF000, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0);
        chk("halt_flushed", 128'({halted, instr_ready, out_valid}), 128'({1'b0, 1'b1, 1'b0}));
        step(1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("halt_taken", 128'({halted, out_valid, instr_ready}), 128'({1'b1, 1'b1, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0288, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        end
        chk("halted_idle", 128'({halted, out_valid, instr_ready}), 128'({1'b1, 1'b0, 1'b0}));
        do_reset();
        chk("halt_reset", 128'({halted, instr_ready}), 128'({1'b0, 1'b1}));

        // Reset asserted mid-stall.
        step(1'b1, 16'h0288, 1'b1, 1'b0, 1'b1, 3'd5, 16'h00AA);
        stall = 1'b0;
        do_reset();
        chk("stall_reset_ready", 128'(instr_ready), 128'd1);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'hE;
            step($urandom_range(3, 0) != 0, ins, $urandom_range(3, 0) == 0,
                 $urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1,
                 3'($urandom_range(7, 0)), 16'($urandom));
        end
        snap = m_out;
        chk("random_end_valid_known", 128'(^dut_out() === 1'bx), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instr_valid  input  1  fetch offers instr this cycle.
REQ-005 instr  input  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs, [8:0] imm9, [5:0] disp6.
REQ-006 instr_ready  output  1  decode accepts instr this cycle.
REQ-007 stall  input  1  downstream hold; output register frozen.
REQ-008 flush  input  1  taken branch; kill register contents and incoming instr.
REQ-009 wb_we / wb_addr / wb_data  input  1/3/16  register-file write port from writeback.
REQ-010 out_valid  output  1  execution-stage fields hold a live instruction.
REQ-011 pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump  output  1 each  execution control flags.
REQ-012 alith  output  2  00 add, 01 sub, 10 and, 11 or.
REQ-013 rd_addr  output  3  destination register; 0 = no writeback.
REQ-014 disp6 / imm9  output  6/9  raw immediate fields.
REQ-015 rd / rs  output  16 each  register-file read values.
REQ-016 source1 / source2  output  16 each  ALU operands.
REQ-017 halted  output  1  HALT retired into the output register; decode stopped.

Function
REQ-018 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 SUBI, 6 INCR, 7 DECR, 8 LDI, 9 LD, A ST, B BEQ, C BGT, D JUMP, E NOP, F HALT.
REQ-019 R-type (0-3): source1=R[rd], source2=R[rs], alith=opcode[1:0].
REQ-020 ADDI/SUBI: source2=zero-extended imm9; INCR/DECR: source2=1; all with source1=R[rd].
REQ-021 LDI: is_ldi=1, source2=zero-extended imm9, source1=R[rd].
REQ-022 LD/ST: is_ld_st=1, source1=R[rd], source2=sign-extended disp6; ST: mem_w=1, rd_addr=0.
REQ-023 BEQ/BGT: pc_w=1, is_eq=1 for BEQ only, rd_addr=0, source1=0, source2=sign-extended disp6.
REQ-024 JUMP: pc_w=1, is_jump=1, rd_addr=0, source1=0, source2=sign-extended imm9.
REQ-025 NOP/HALT/bubble: all flags 0, rd_addr=0, source1=source2=0.
REQ-026 Transfer occurs when instr_valid && instr_ready; outputs update one cycle later (1-cycle latency).
REQ-027 instr_ready = !stall && state==RUN.
REQ-028 stall=1: all outputs hold their value; register-file write still occurs.
REQ-029 flush=1 (has priority over stall): next cycle out_valid=0, fields per REQ-025; incoming instr discarded.
REQ-030 No transfer and no stall: next cycle out_valid=0 (bubble).
REQ-031 Register file 8x16; R0 reads 0 and writes to R0 are discarded; wb write on clk edge when wb_we.
REQ-032 FSM: RUN --(HALT transferred, no flush)--> HALTED; HALTED is left only by reset; halted=1 in HALTED.
REQ-033 HALT transferred together with flush SHALL be discarded; state stays RUN.

Reset
REQ-034 rst_n low SHALL asynchronously clear all outputs to 0, out_valid=0, halted=0, state=RUN, all registers to 0.
REQ-035 Reset mid-stall or in HALTED SHALL return to RUN with instr_ready=1 after rst_n deasserts.

Configuration
REQ-036 Macro DECODE_WB_BYPASS_EN defined: a read of register wb_addr in the same cycle as wb_we returns wb_data.
REQ-037 Macro undefined: the same read returns the old register value; software must insert one NOP.

Verification
REQ-038 Write R1=10, R2=20; ADD 0x0288 -> next cycle source1=10, source2=20, alith=00, rd_addr=1, out_valid=1.
REQ-039 LD 0x9283 with R1=10 -> is_ld_st=1, source1=10, source2=3, rd_addr=1; ST 0xA283 -> mem_w=1, rd_addr=0.
REQ-040 BEQ with disp6=0x3F -> pc_w=1, is_eq=1, source2=0xFFFF; flush asserted in the same cycle -> next cycle out_valid=0.
REQ-041 stall held 3 cycles during ADDI R1,3 -> outputs constant and instr_ready=0; release -> next instruction decoded.
REQ-042 HALT -> halted=1 and instr_ready=0 forever; pulse rst_n -> halted=0, instr_ready=1.
REQ-043 wb_we to R3=0x1234 with an ADD reading R3 in the same cycle -> source1=0x1234 with macro, old value without.
